// File: rtl/fp_add_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_if
//  Description : Operand/result bundle for the fp_add floating-point adder.
//                The master drives the packed operands; the slave (adder)
//                returns the sum as separate sign/exponent/fraction fields.
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_add_if #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) ();
  localparam int W = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH;

  logic [W-1:0]              A_FP;
  logic [W-1:0]              B_FP;
  logic                      sign;
  logic [EXPONENT_WIDTH-1:0] exponent;
  logic [MANTISSA_WIDTH-1:0] mantissa;

  modport master (
    output A_FP,
    output B_FP,
    input  sign,
    input  exponent,
    input  mantissa
  );

  modport slave (
    input  A_FP,
    input  B_FP,
    output sign,
    output exponent,
    output mantissa
  );
endinterface
`default_nettype wire

// File: rtl/fp_add.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add
//  Description : IEEE-754 binary floating-point adder, round-to-nearest-even,
//                subnormals flushed to zero, combinational compute with a
//                single output register (latency 1, throughput 1/cycle).
//  Revision    : 1.0  initial release
// ============================================================================
module fp_add #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  fp_add_if.slave    bus
);
  localparam int E     = EXPONENT_WIDTH;
  localparam int M     = MANTISSA_WIDTH;
  // Extended magnitude: hidden bit, fraction, guard, round, sticky.
  localparam int XW    = M + 4;
  localparam int LZW   = $clog2(XW + 1);

  localparam logic [E-1:0]   c_emax    = {E{1'b1}};
  localparam logic [E-1:0]   c_sat     = E'(M + 3);
  localparam logic [M-1:0]   c_qnan_m  = {1'b1, {(M-1){1'b0}}};
  localparam logic [E+1:0]   c_emax_x  = {2'b00, {E{1'b1}}};

  // Leading-zero count of the extended difference (XW when all zero).
  function automatic logic [LZW-1:0] lzc(input logic [XW-1:0] v);
    lzc = LZW'(XW);
    for (int i = 0; i < XW; i++) begin
      if (v[i]) lzc = LZW'(XW - 1 - i);
    end
  endfunction

  // Unpacked operand fields
  logic         w_sa, w_sb;
  logic [E-1:0] w_ea, w_eb;
  logic [M-1:0] w_fa, w_fb;
  assign {w_sa, w_ea, w_fa} = bus.A_FP;
  assign {w_sb, w_eb, w_fb} = bus.B_FP;

  // Exponent 0 covers both true zero and flushed subnormals.
  logic w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_nan  = (w_ea == c_emax) && (w_fa != '0);
  assign w_b_nan  = (w_eb == c_emax) && (w_fb != '0);
  assign w_a_inf  = (w_ea == c_emax) && (w_fa == '0);
  assign w_b_inf  = (w_eb == c_emax) && (w_fb == '0);

  // Order by magnitude: exponent first, then fraction.
  logic         w_a_big;
  logic         w_s_big;
  logic [E-1:0] w_e_big, w_e_sml, w_diff;
  logic [M:0]   w_m_big, w_m_sml;
  assign w_a_big = (w_ea > w_eb) || ((w_ea == w_eb) && (w_fa >= w_fb));
  assign w_s_big = w_a_big ? w_sa : w_sb;
  assign w_e_big = w_a_big ? w_ea : w_eb;
  assign w_e_sml = w_a_big ? w_eb : w_ea;
  assign w_m_big = w_a_big ? {1'b1, w_fa} : {1'b1, w_fb};
  assign w_m_sml = w_a_big ? {1'b1, w_fb} : {1'b1, w_fa};
  assign w_diff  = w_e_big - w_e_sml;

  logic [XW-1:0]   w_big_ext, w_sml_ext, w_shifted, w_aligned;
  logic            w_lost;
  logic [XW:0]     w_sum;
  logic [XW-1:0]   w_dif;
  logic [LZW-1:0]  w_lz;
  logic [XW-1:0]   w_norm;
  logic [E+1:0]    w_exp_n;
  logic [E+1:0]    w_exp_r;
  logic [M+1:0]    w_rnd;
  logic [M-1:0]    w_frac_r;
  logic            w_res_sign;
  logic [E-1:0]    w_res_exp;
  logic [M-1:0]    w_res_man;

  assign w_big_ext = {w_m_big, 3'b000};
  assign w_sml_ext = {w_m_sml, 3'b000};

  // Align the small operand, folding every shifted-out bit into sticky.
  always_comb begin
    w_shifted = '0;
    w_lost    = 1'b0;
    w_aligned = '0;
    if (w_diff >= c_sat) begin
      w_aligned = {{(XW-1){1'b0}}, 1'b1};
    end else begin
      w_shifted = w_sml_ext >> w_diff;
      w_lost    = ((w_shifted << w_diff) != w_sml_ext);
      w_aligned = w_shifted | {{(XW-1){1'b0}}, w_lost};
    end
  end

  assign w_sum = {1'b0, w_big_ext} + {1'b0, w_aligned};
  assign w_dif = w_big_ext - w_aligned;
  assign w_lz  = lzc(w_dif);

  // Normalize the raw sum/difference and track the working exponent.
  always_comb begin
    w_norm  = '0;
    w_exp_n = {2'b00, w_e_big};
    if (w_sa == w_sb) begin
      if (w_sum[XW]) begin
        w_norm  = {w_sum[XW:2], w_sum[1] | w_sum[0]};
        w_exp_n = {2'b00, w_e_big} + (E+2)'(1);
      end else begin
        w_norm  = w_sum[XW-1:0];
      end
    end else begin
      w_norm  = w_dif << w_lz;
      w_exp_n = {2'b00, w_e_big} - (E+2)'(w_lz);
    end
  end

  // Round to nearest even; a carry out of the significand bumps the exponent.
  always_comb begin
    w_rnd    = {1'b0, w_norm[XW-1:3]}
             + (M+2)'(w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]));
    w_exp_r  = w_exp_n;
    w_frac_r = w_rnd[M-1:0];
    if (w_rnd[M+1]) begin
      w_frac_r = '0;
      w_exp_r  = w_exp_n + (E+2)'(1);
    end
  end

  // Result selection: specials, zero operands, cancellation, range limits.
  always_comb begin
    w_res_sign = w_s_big;
    w_res_exp  = w_exp_r[E-1:0];
    w_res_man  = w_frac_r;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      w_res_sign = 1'b0;
      w_res_exp  = c_emax;
      w_res_man  = c_qnan_m;
    end else if (w_a_inf) begin
      w_res_sign = w_sa;
      w_res_exp  = c_emax;
      w_res_man  = '0;
    end else if (w_b_inf) begin
      w_res_sign = w_sb;
      w_res_exp  = c_emax;
      w_res_man  = '0;
    end else if (w_a_zero && w_b_zero) begin
      w_res_sign = 1'b0;
      w_res_exp  = '0;
      w_res_man  = '0;
    end else if (w_a_zero) begin
      {w_res_sign, w_res_exp, w_res_man} = bus.B_FP;
    end else if (w_b_zero) begin
      {w_res_sign, w_res_exp, w_res_man} = bus.A_FP;
    end else if ((w_sa != w_sb) && (w_dif == '0)) begin
      w_res_sign = 1'b0;
      w_res_exp  = '0;
      w_res_man  = '0;
    end else if ($signed(w_exp_n) <= 0) begin
      w_res_exp  = '0;
      w_res_man  = '0;
    end else if ($signed(w_exp_r) >= $signed(c_emax_x)) begin
      w_res_exp  = c_emax;
      w_res_man  = '0;
    end
  end

  logic         r_sign;
  logic [E-1:0] r_exp;
  logic [M-1:0] r_man;

  // Output register; reset presents +0.0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_man  <= '0;
    end else begin
      r_sign <= w_res_sign;
      r_exp  <= w_res_exp;
      r_man  <= w_res_man;
    end
  end

  assign bus.sign     = r_sign;
  assign bus.exponent = r_exp;
  assign bus.mantissa = r_man;
endmodule
`default_nettype wire

// File: tb/tb_fp_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add
//  Description : Directed self-checking bench for fp_add (single precision).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_add;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fp_add_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) bus ();

  fp_add #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] obs;
  assign obs = {bus.sign, bus.exponent, bus.mantissa};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic op(input string tag, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] expv);
    bus.A_FP = a;
    bus.B_FP = b;
    @(posedge clk);
    #1;
    check(tag, expv);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    bus.A_FP = 32'h0;
    bus.B_FP = 32'h0;
    #12;
    check("reset_state", 32'h0000_0000);
    rst_n = 1'b1;
    #1;

    op("basic_7.25+0.375", 32'h40E80000, 32'h3EC00000, 32'h40F40000);
    op("basic_6+7",        32'h40C00000, 32'h40E00000, 32'h41500000);
    op("basic_10+2.5",     32'h41200000, 32'h40200000, 32'h41480000);

    op("neg_sum",          32'hC0E00000, 32'hC0400000, 32'hC1200000);
    op("sub_pos",          32'h40E00000, 32'hC0400000, 32'h40800000);
    op("sub_neg",          32'hC0E00000, 32'h40400000, 32'hC0800000);
    op("sub_65-63",        32'h42820000, 32'hC27C0000, 32'h40000000);
    op("cancel_4",         32'h40800000, 32'hC0800000, 32'h00000000);
    op("cancel_half",      32'hBF000000, 32'h3F000000, 32'h00000000);

    op("mix_-26",          32'hC2100000, 32'h41200000, 32'hC1D00000);
    op("mix_-79",          32'h41100000, 32'hC2B00000, 32'hC29E0000);
    op("mix_-132",         32'hC2C60000, 32'hC2040000, 32'hC3040000);
    op("mix_-2",           32'h40200000, 32'hC0900000, 32'hC0000000);
    op("mix_0.2",          32'h3F000000, 32'hBE999998, 32'h3E4CCCD0);
    op("mix_0.7",          32'h3E4CCCCC, 32'h3F000000, 32'h3F333333);

    op("zero_zero",        32'h00000000, 32'h00000000, 32'h00000000);
    op("zero_plus_12",     32'h00000000, 32'h41400000, 32'h41400000);
    op("round_tie_even",   32'h3F800000, 32'h33800000, 32'h3F800000);
    op("round_up",         32'h3F800000, 32'h33C00000, 32'h3F800001);
    op("subnormal_flush",  32'h00000001, 32'h40400000, 32'h40400000);
    op("negzero_negzero",  32'h80000000, 32'h80000000, 32'h00000000);

    op("inf_minus_inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000);
    op("nan_in",           32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    op("ninf_plus_fin",    32'h3F800000, 32'hFF800000, 32'hFF800000);
    op("overflow",         32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);

    // Asynchronous reset mid-stream: clears without any clock edge.
    bus.A_FP = 32'h40C00000;
    bus.B_FP = 32'h40E00000;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 32'h00000000);
    @(posedge clk);
    #1;
    check("reset_held", 32'h00000000);
    #2;
    rst_n = 1'b1;
    #1;
    check("release_no_edge", 32'h00000000);
    @(posedge clk);
    #1;
    check("first_after_release", 32'h41500000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fp_add.md
# fp_add

Pipelined IEEE-754 binary floating-point adder used in the CNN datapath to accumulate products and partial sums. It takes two packed operands and returns the sum as separate sign, biased exponent and fraction fields. The result is registered with a fixed latency of one clock. Single precision (8/23) is the deployed configuration.

## Interface
- EXPONENT_WIDTH, default 8: biased exponent field width; bias = 2^(EXPONENT_WIDTH-1)-1.
- MANTISSA_WIDTH, default 23: stored fraction width; the hidden bit is implicit.
- Let W = 1+EXPONENT_WIDTH+MANTISSA_WIDTH.
- One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A_FP  input  W  operand A, packed {sign, exponent, fraction}.
- B_FP  input  W  operand B, same format.
- sign  output  1  sign of A+B.
- exponent  output  EXPONENT_WIDTH  biased exponent of A+B.
- mantissa  output  MANTISSA_WIDTH  fraction of A+B, hidden bit excluded.

## Operation
- Unpack both operands and prepend the hidden bit: 1 if exponent≠0, else 0.
- Subnormal inputs (exponent 0, fraction ≠ 0) are flushed to zero before use.
- Swap operands so the larger magnitude is the big operand: compare exponent first, then fraction.
- Shift the small operand right by the exponent difference.
  - Keep guard, round and sticky bits.
  - A shift ≥ MANTISSA_WIDTH+3 leaves only the sticky bit.
- Same signs: add the magnitudes. On carry-out, shift right 1 (OR the lost bit into sticky) and increment the exponent.
- Different signs: subtract small from big. Normalize left with a leading-zero count and decrement the exponent by that count.
- Rounding is round-to-nearest-even using guard/round/sticky.
  - A rounding carry renormalizes: fraction becomes 0, exponent +1.
- Result sign is the sign of the larger-magnitude operand.
- Exact cancellation (including -x + x and 0 + 0) gives +0: sign 0, exponent 0, mantissa 0.
- A zero operand returns the other operand unchanged.
- Exponent underflow (normalized exponent ≤ 0) flushes to a signed zero.
- Exponent overflow (≥ all-ones) gives signed infinity: exponent all-ones, mantissa 0.
- Special inputs:
  - Either operand NaN gives a quiet NaN: sign 0, exponent all-ones, mantissa MSB 1, rest 0.
  - +inf + -inf gives the same quiet NaN.
  - inf + finite gives that inf.
  - inf + same-sign inf gives that inf.
- No exception flags are produced.

## Timing
- Fully combinational compute from A_FP/B_FP.
- Output register sits on rising clk. Latency is 1 cycle and throughput is one operation per cycle.
- Inputs sampled at edge N appear on the outputs after edge N and stay stable until edge N+1.
- There is no valid/ready handshake. Every edge captures the current inputs.
- rst_n low asynchronously clears sign, exponent and mantissa to 0 (a +0.0 output).
- While rst_n is low the outputs stay at 0.
- The first capture is at the first rising edge after rst_n deasserts. Any operation in flight when reset asserts is discarded.
- Inputs must meet setup/hold to clk. No input registers exist.

## Test plan
All cases: apply the inputs, one edge later check {sign, exponent, mantissa}.
- Basic sums:
  - 0x40E80000 + 0x3EC00000 (7.25+0.375) -> 0x40F40000 (7.625).
  - 0x40C00000 + 0x40E00000 (6+7) -> 0x41500000.
  - 0x41200000 + 0x40200000 (10+2.5) -> 0x41480000.
- Signs and cancellation:
  - 0xC0E00000 + 0xC0400000 -> 0xC1200000 (-10).
  - 0x40E00000 + 0xC0400000 -> 0x40800000 (4).
  - 0xC0E00000 + 0x40400000 -> 0xC0800000 (-4).
  - 0x42820000 + 0xC27C0000 (65-63) -> 0x40000000 (2).
  - 0x40800000 + 0xC0800000 -> 0x00000000.
  - 0xBF000000 + 0x3F000000 -> 0x00000000.
- Mixed magnitudes:
  - 0xC2100000 + 0x41200000 -> 0xC1D00000 (-26).
  - 0x41100000 + 0xC2B00000 -> 0xC29E0000 (-79).
  - 0xC2C60000 + 0xC2040000 -> 0xC3040000 (-132).
  - 0x40200000 + 0xC0900000 -> 0xC0000000 (-2).
  - 0x3F000000 + 0xBE999998 -> 0x3E4CCCD0.
  - 0x3E4CCCCC + 0x3F000000 -> 0x3F333333.
- Zeros and rounding:
  - 0 + 0 -> 0.
  - 0 + 0x41400000 -> 0x41400000.
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000.
  - 0x3F800000 + 0x33C00000 -> 0x3F800001.
- Specials and reset:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - Assert rst_n mid-stream -> outputs 0 immediately, without waiting for a clock edge.
  - Release rst_n -> the first result appears one edge later.
